// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, register-file sizes,
// word field positions, error codes and FSM state encoding.
package inst_encoder_pkg;

    localparam int WORD_W = 32;
    localparam int S_REGS = 32;
    localparam int P_REGS = 16;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MPY  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_CMP  = 5'd9;
    localparam logic [4:0] OP_MOV  = 5'd10;
    localparam logic [4:0] OP_BR   = 5'd11;
    localparam logic [4:0] OP_HALT = 5'd12;

    localparam int F_OP_LSB  = 27;
    localparam int F_USE_IMM = 26;
    localparam int F_SEXT    = 25;
    localparam int F_Z_LSB   = 16;
    localparam int F_CC_LSB  = 10;
    localparam int F_A_LSB   = 5;
    localparam int F_B_LSB   = 0;
    localparam int F_IMM_LSB = 0;

    typedef enum logic [1:0] {
        ERR_OPCODE = 2'd0,
        ERR_IMM    = 2'd1,
        ERR_REG    = 2'd2,
        ERR_ADDR   = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // ALU opcodes occupy the contiguous range ADD..CMP.
    function automatic logic is_alu(input logic [4:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Descriptor handshake plus program-memory write bus of the instruction encoder.
// master = loader/memory side, slave = encoder.
interface inst_encoder_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [4:0]        in_z;
    logic [4:0]        in_a;
    logic [4:0]        in_b;
    logic [15:0]       in_imm;
    logic              in_use_imm;
    logic              in_sext;
    logic [2:0]        in_cc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_opcode, in_z, in_a, in_b, in_imm, in_use_imm, in_sext, in_cc,
        output mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_z, in_a, in_b, in_imm, in_use_imm, in_sext, in_cc,
        input  mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational descriptor-to-word packer with legality check; the first failing
// check in priority order (opcode, immediate range, register range) sets code.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  z,
    input  logic [4:0]  a,
    input  logic [4:0]  b,
    input  logic [15:0] imm,
    input  logic        use_imm,
    input  logic        sext,
    input  logic [2:0]  cc,
    output logic [31:0] word,
    output logic        illegal,
    output err_code_t   code
);

    logic alu_op;
    logic imm_bad;

    assign alu_op = is_alu(opcode);

    // A signed 5-bit immediate is representable only when bits 15..4 are a pure sign extension.
    assign imm_bad = sext ? ~((&imm[15:4]) | ~(|imm[15:4])) : (|imm[15:5]);

    always_comb begin
        word = '0;
        word[F_OP_LSB +: 5] = opcode;
        if (alu_op) begin
            word[F_USE_IMM]     = use_imm;
            word[F_SEXT]        = use_imm & sext;
            word[F_Z_LSB +: 5]  = z;
            word[F_A_LSB +: 5]  = a;
            word[F_B_LSB +: 5]  = use_imm ? imm[4:0] : b;
            if (opcode == OP_CMP) begin
                word[F_CC_LSB +: 3] = cc;
            end
        end else if (opcode == OP_MOV) begin
            word[F_Z_LSB +: 5]    = z;
            word[F_IMM_LSB +: 16] = imm;
        end else if (opcode == OP_BR) begin
            word[F_Z_LSB +: 4]    = a[3:0];
            word[F_IMM_LSB +: 16] = imm;
        end
    end

    always_comb begin
        illegal = 1'b0;
        code    = ERR_OPCODE;
        if (opcode > OP_HALT) begin
            illegal = 1'b1;
            code    = ERR_OPCODE;
        end else if (alu_op && use_imm && imm_bad) begin
            illegal = 1'b1;
            code    = ERR_IMM;
        end else if ((opcode == OP_BR) && a[4]) begin
            illegal = 1'b1;
            code    = ERR_REG;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Streams encoded instruction words into program memory through a single
// registered output stage; a stream ends on HALT or on the first error.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_encoder_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            state_reg, state_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_halt_reg, out_halt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [WIDTH-1:0]  wdata_reg, wdata_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    err_code_t         err_code_reg, err_code_next;

    logic [31:0]       pack_word;
    logic              pack_illegal;
    err_code_t         pack_code;

    logic              write_done;
    logic              at_last;
    logic              in_ready_int;
    logic              accept;

    inst_pack u_pack (
        .opcode  (bus.in_opcode),
        .z       (bus.in_z),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .imm     (bus.in_imm),
        .use_imm (bus.in_use_imm),
        .sext    (bus.in_sext),
        .cc      (bus.in_cc),
        .word    (pack_word),
        .illegal (pack_illegal),
        .code    (pack_code)
    );

    assign write_done = out_valid_reg && bus.mem_ready;
    assign at_last    = out_valid_reg && (addr_reg == ADDR_LAST);

    // A word sitting at the last address is about to overflow the memory, so
    // nothing may be loaded behind it: the stream stops with that word.
    assign in_ready_int = (state_reg == ST_RUN) &&
                          (!out_valid_reg || (bus.mem_ready && !at_last));
    assign accept       = bus.in_valid && in_ready_int;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_halt_next  = out_halt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        count_next     = count_reg;
        done_next      = done_reg;
        err_next       = err_reg;
        err_code_next  = err_code_reg;

        if (write_done) begin
            out_valid_next = 1'b0;
            addr_next      = addr_reg + 1'b1;
            count_next     = count_reg + 1'b1;
        end

        unique case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next     = ST_RUN;
                    addr_next      = base_addr;
                    count_next     = '0;
                    done_next      = 1'b0;
                    err_next       = 1'b0;
                    err_code_next  = ERR_OPCODE;
                    out_valid_next = 1'b0;
                end
            end
            ST_RUN: begin
                if (write_done && at_last) begin
                    state_next    = ST_ERR;
                    err_next      = 1'b1;
                    err_code_next = ERR_ADDR;
                end else if (accept) begin
                    if (pack_illegal) begin
                        state_next    = ST_ERR;
                        err_next      = 1'b1;
                        err_code_next = pack_code;
                    end else begin
                        out_valid_next = 1'b1;
                        out_halt_next  = (bus.in_opcode == OP_HALT);
                        wdata_next     = WIDTH'(pack_word);
                        if (bus.in_opcode == OP_HALT) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (write_done) begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_halt_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            count_reg     <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_OPCODE;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_halt_reg  <= out_halt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            count_reg     <= count_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.mem_we    = out_valid_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign busy          = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done          = done_reg;
    assign err           = err_reg;
    assign err_code      = err_code_reg;
    assign count         = count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized
// programs checked against an arithmetic model of the word format.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc       = 0;
    int stall_end = -1;
    bit rand_mode = 1'b0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    inst_encoder_if #(.WIDTH(32), .ADDR_W(AW)) bus ();

    inst_encoder #(.WIDTH(32), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Memory-side ready: forced low through stall_end, otherwise 1 or random.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cyc <= stall_end) bus.mem_ready = 1'b0;
        else if (rand_mode)   bus.mem_ready = ($urandom_range(0, 3) != 0);
        else                  bus.mem_ready = 1'b1;
    end

    // Log every write that will complete at the coming rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.mem_we && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference word format, built with plain arithmetic from the field rules.
    function automatic logic [31:0] model_word(int op, int z, int a, int b, int imm, int ui, int sx, int cc);
        longint w;
        w = longint'(op) * 134217728;
        if (op <= int'(OP_CMP)) begin
            w += ui * 67108864 + ui * sx * 33554432 + z * 65536 + a * 32 + (ui != 0 ? imm % 32 : b);
            if (op == int'(OP_CMP)) w += cc * 1024;
        end else if (op == int'(OP_MOV)) begin
            w += z * 65536 + imm;
        end else if (op == int'(OP_BR)) begin
            w += (a % 16) * 65536 + imm;
        end
        return w[31:0];
    endfunction

    // Returns -1 for a legal descriptor, otherwise the expected error code.
    function automatic int model_check(int op, int a, int imm, int ui, int sx);
        int s;
        if (op > int'(OP_HALT)) return 0;
        if (op <= int'(OP_CMP) && ui != 0) begin
            if (sx == 0) begin
                if (imm >= 32) return 1;
            end else begin
                s = (imm >= 32768) ? imm - 65536 : imm;
                if (s < -16 || s > 15) return 1;
            end
        end
        if (op == int'(OP_BR) && a >= 16) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] wr_data(int idx);
        return (idx < wr_data_q.size()) ? wr_data_q[idx] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [AW-1:0] wr_addr(int idx);
        return (idx < wr_addr_q.size()) ? wr_addr_q[idx] : {AW{1'bx}};
    endfunction

    task automatic do_start(input logic [AW-1:0] b);
        @(negedge clk);
        base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] z, input logic [4:0] a, input logic [4:0] b,
                        input logic [15:0] imm, input logic ui, input logic sx, input logic [2:0] cc,
                        output bit ok);
        @(negedge clk);
        bus.in_opcode = op; bus.in_z = z; bus.in_a = a; bus.in_b = b;
        bus.in_imm = imm; bus.in_use_imm = ui; bus.in_sext = sx; bus.in_cc = cc;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #3;
            if (!busy && !bus.mem_we) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.mem_we, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 00000", {bus.in_ready, bus.mem_we, busy, done, err});
        end
        n_checks++;
        if ({err_code, bus.mem_addr, bus.mem_wdata, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: err_code=%0d addr=%h wdata=%h count=%0d, required all 0",
                     err_code, bus.mem_addr, bus.mem_wdata, count);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, bus.in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, bus.in_ready);
        end
        $display("reset: checked reset and idle state");
    endtask

    task automatic test_signed_imm;
        bit ok1, ok2, ok3;
        logic [31:0] w;
        do_start(10'h010);
        send(OP_ADD, 5'd3, 5'd1, 5'd0, 16'hFFFD, 1'b1, 1'b1, 3'd0, ok1);
        send(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok2);
        wait_idle(ok3);
        w = wr_data(0);
        n_checks++;
        if ({ok1, ok2, ok3} !== 3'b111) begin
            n_fail++;
            $display("FAIL signed_imm_handshake: got %b, required 111", {ok1, ok2, ok3});
        end
        n_checks++;
        if (wr_addr(0) !== 10'h010) begin
            n_fail++;
            $display("FAIL signed_imm_addr: got %h, required 010", wr_addr(0));
        end
        n_checks++;
        if ({w[31:27], w[26:25], w[20:16], w[9:5], w[4:0]} !== {OP_ADD, 2'b11, 5'd3, 5'd1, 5'b11101}) begin
            n_fail++;
            $display("FAIL signed_imm_fields: word %h", w);
        end
        n_checks++;
        if (w !== model_word(int'(OP_ADD), 3, 1, 0, 16'hFFFD, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL signed_imm_word: got %h, required %h", w, model_word(int'(OP_ADD), 3, 1, 0, 16'hFFFD, 1, 1, 0));
        end
        $display("signed_imm: ADD word %h at %h", w, wr_addr(0));
    endtask

    task automatic test_stream_stall;
        bit ok1, ok2, ok3, ok4;
        logic [31:0] w_mov, w_br, w_halt;
        int bad_hold;
        w_mov  = model_word(int'(OP_MOV), 7, 0, 0, 16'hBEEF, 0, 0, 0);
        w_br   = model_word(int'(OP_BR), 0, 2, 0, 16'h0004, 0, 0, 0);
        w_halt = model_word(int'(OP_HALT), 0, 0, 0, 0, 0, 0, 0);
        do_start(10'h010);
        send(OP_MOV, 5'd7, 5'd0, 5'd0, 16'hBEEF, 1'b0, 1'b0, 3'd0, ok1);
        stall_end = cyc + 3;
        bad_hold = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (!(bus.mem_we === 1'b1 && bus.mem_addr === 10'h010 && bus.mem_wdata === w_mov
                  && bus.in_ready === 1'b0)) bad_hold++;
        end
        n_checks++;
        if (bad_hold !== 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable stall cycles, required 0", bad_hold);
        end
        send(OP_BR, 5'd0, 5'd2, 5'd0, 16'h0004, 1'b0, 1'b0, 3'd0, ok2);
        send(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok3);
        wait_idle(ok4);
        n_checks++;
        if ({ok1, ok2, ok3, ok4} !== 4'b1111) begin
            n_fail++;
            $display("FAIL stream_handshake: got %b, required 1111", {ok1, ok2, ok3, ok4});
        end
        n_checks++;
        if ({wr_addr(0), wr_addr(1), wr_addr(2)} !== {10'h010, 10'h011, 10'h012} || wr_addr_q.size() != 3) begin
            n_fail++;
            $display("FAIL stream_addrs: got %h %h %h (n=%0d), required 010 011 012",
                     wr_addr(0), wr_addr(1), wr_addr(2), wr_addr_q.size());
        end
        n_checks++;
        if ({wr_data(0), wr_data(1), wr_data(2)} !== {w_mov, w_br, w_halt}) begin
            n_fail++;
            $display("FAIL stream_words: got %h %h %h, required %h %h %h",
                     wr_data(0), wr_data(1), wr_data(2), w_mov, w_br, w_halt);
        end
        n_checks++;
        if (done !== 1'b1 || count !== 11'd3) begin
            n_fail++;
            $display("FAIL stream_done: done=%b count=%0d, required 1 3", done, count);
        end
        $display("stream_stall: %0d writes, done=%b count=%0d", wr_addr_q.size(), done, count);
    endtask

    task automatic test_cmp;
        bit ok1, ok2, ok3;
        logic [31:0] w;
        do_start(10'h020);
        send(OP_CMP, 5'd1, 5'd4, 5'd5, 16'h0, 1'b0, 1'b0, 3'b101, ok1);
        send(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok2);
        wait_idle(ok3);
        w = wr_data(0);
        n_checks++;
        if ({w[12:10], w[26], w[4:0]} !== {3'b101, 1'b0, 5'd5}) begin
            n_fail++;
            $display("FAIL cmp_fields: word %h, required cc=101 use_imm=0 b=5", w);
        end
        n_checks++;
        if (w !== model_word(int'(OP_CMP), 1, 4, 5, 0, 0, 0, 5) || !(ok1 && ok2 && ok3)) begin
            n_fail++;
            $display("FAIL cmp_word: got %h, required %h", w, model_word(int'(OP_CMP), 1, 4, 5, 0, 0, 0, 5));
        end
        $display("cmp: word %h", w);
    endtask

    task automatic test_imm_error;
        bit ok1, ok2, ok3;
        int ready_seen;
        do_start(10'h030);
        send(OP_ADD, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0, 1'b0, 3'd0, ok1);
        send(OP_ADD, 5'd2, 5'd3, 5'd4, 16'h0020, 1'b1, 1'b0, 3'd0, ok2);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL imm_err_timing: err=%b code=%0d one cycle after accept, required 1 1", err, err_code);
        end
        wait_idle(ok3);
        n_checks++;
        if (wr_addr_q.size() != 1 || wr_addr(0) !== 10'h030 || wr_data(0) !== model_word(int'(OP_ADD), 2, 3, 4, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL imm_err_prior_word: n=%0d addr=%h word=%h, required 1 write at 030", wr_addr_q.size(), wr_addr(0), wr_data(0));
        end
        bus.in_valid = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (bus.in_ready !== 1'b0) ready_seen++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (ready_seen != 0 || err !== 1'b1 || err_code !== 2'd1 || done !== 1'b0 || !(ok1 && ok2 && ok3)) begin
            n_fail++;
            $display("FAIL imm_err_hold: ready_seen=%0d err=%b code=%0d done=%b, required 0 1 1 0", ready_seen, err, err_code, done);
        end
        $display("imm_error: err=%b err_code=%0d writes=%0d", err, err_code, wr_addr_q.size());
    endtask

    task automatic test_addr_overflow;
        bit ok1, ok2, ok3, ok4;
        do_start(10'h3FE);
        send(OP_ADD, 5'd1, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok1);
        send(OP_SUB, 5'd2, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok2);
        send(OP_XOR, 5'd3, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok3);
        wait_idle(ok4);
        n_checks++;
        if ({ok1, ok2, ok3, ok4} !== 4'b1101) begin
            n_fail++;
            $display("FAIL ovf_handshake: accepted pattern %b, required 1101", {ok1, ok2, ok3, ok4});
        end
        n_checks++;
        if (wr_addr_q.size() != 2 || wr_addr(0) !== 10'h3FE || wr_addr(1) !== 10'h3FF
            || wr_data(1) !== model_word(int'(OP_SUB), 2, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL ovf_writes: n=%0d addrs %h %h, required 2 at 3fe 3ff", wr_addr_q.size(), wr_addr(0), wr_addr(1));
        end
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || count !== 11'd2) begin
            n_fail++;
            $display("FAIL ovf_status: err=%b code=%0d count=%0d, required 1 3 2", err, err_code, count);
        end
        $display("addr_overflow: writes=%0d err_code=%0d", wr_addr_q.size(), err_code);
    endtask

    task automatic test_reset_midstream;
        bit ok1, ok2, ok3, ok4;
        do_start(10'h040);
        stall_end = cyc + 50;
        send(OP_MOV, 5'd5, 5'd0, 5'd0, 16'h1234, 1'b0, 1'b0, 3'd0, ok1);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_ready !== 1'b0 || !ok1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: mem_we=%b mem_ready=%b, required 1 0", bus.mem_we, bus.mem_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_we, busy, done, err, bus.in_ready} !== 5'b0 || {err_code, bus.mem_addr, bus.mem_wdata, count} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_values: we=%b busy=%b addr=%h wdata=%h count=%0d, required all 0",
                     bus.mem_we, busy, bus.mem_addr, bus.mem_wdata, count);
        end
        @(negedge clk);
        rst = 1'b0;
        stall_end = -1;
        do_start(10'h050);
        send(OP_MOV, 5'd6, 5'd0, 5'd0, 16'h5678, 1'b0, 1'b0, 3'd0, ok2);
        send(OP_HALT, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'd0, ok3);
        wait_idle(ok4);
        n_checks++;
        if (wr_addr_q.size() != 2 || wr_addr(0) !== 10'h050 || wr_data(0) !== model_word(int'(OP_MOV), 6, 0, 0, 16'h5678, 0, 0, 0)
            || done !== 1'b1 || count !== 11'd2 || !(ok2 && ok3 && ok4)) begin
            n_fail++;
            $display("FAIL rst_mid_recover: n=%0d addr=%h word=%h done=%b count=%0d, required 2 050 done 1 count 2",
                     wr_addr_q.size(), wr_addr(0), wr_data(0), done, count);
        end
        $display("reset_midstream: recovered, writes=%0d done=%b", wr_addr_q.size(), done);
    endtask

    task automatic test_random;
        logic [31:0] exp_q[$];
        logic [4:0]  op, z, a, b;
        logic [15:0] imm;
        logic        ui, sx;
        logic [2:0]  cc;
        int          r, code, exp_code, mism;
        logic [AW-1:0] base;
        bit ok, terminal;
        rand_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            base = AW'($urandom_range(0, 10'h300));
            exp_q.delete();
            exp_code = -1;
            terminal = 1'b0;
            do_start(base);
            for (int k = 0; k < 14 && !terminal; k++) begin
                r = $urandom_range(0, 19);
                if (r < 13)       op = 5'(r);
                else if (r == 19) op = 5'($urandom_range(13, 31));
                else              op = 5'($urandom_range(0, 9));
                z = 5'($urandom_range(0, 31));
                a = 5'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) a = a + 5'd16;
                b = 5'($urandom_range(0, 31));
                ui = 1'($urandom_range(0, 1));
                sx = 1'($urandom_range(0, 1));
                cc = 3'($urandom_range(0, 7));
                imm = 16'($urandom_range(0, 65535));
                if (op <= OP_CMP && ui && $urandom_range(0, 7) != 0)
                    imm = sx ? 16'($signed(6'($urandom_range(0, 31)) - 6'd16)) : 16'($urandom_range(0, 31));
                if (k == 13) op = OP_HALT;
                code = model_check(int'(op), int'(a), int'(imm), int'(ui), int'(sx));
                send(op, z, a, b, imm, ui, sx, cc, ok);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand_accept: prog %0d desc %0d op=%0d not accepted, required accept", p, k, op);
                end
                if (code >= 0) begin
                    exp_code = code;
                    terminal = 1'b1;
                end else begin
                    exp_q.push_back(model_word(int'(op), int'(z), int'(a), int'(b), int'(imm), int'(ui), int'(sx), int'(cc)));
                    if (op == OP_HALT) terminal = 1'b1;
                end
            end
            wait_idle(ok);
            mism = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (wr_data(i) !== exp_q[i] || wr_addr(i) !== AW'(base + AW'(i))) mism++;
            end
            n_checks++;
            if (!ok || mism != 0 || wr_addr_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand_writes: prog %0d got %0d writes (%0d wrong), required %0d", p, wr_addr_q.size(), mism, exp_q.size());
            end
            n_checks++;
            if (exp_code >= 0 ? (err !== 1'b1 || err_code !== 2'(exp_code) || done !== 1'b0)
                              : (done !== 1'b1 || err !== 1'b0)) begin
                n_fail++;
                $display("FAIL rand_status: prog %0d done=%b err=%b code=%0d, required code %0d", p, done, err, err_code, exp_code);
            end
            n_checks++;
            if (count !== 11'(exp_q.size())) begin
                n_fail++;
                $display("FAIL rand_count: prog %0d got %0d, required %0d", p, count, exp_q.size());
            end
            $display("random prog %0d: base=%h words=%0d expected_code=%0d", p, base, exp_q.size(), exp_code);
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_z = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_imm = '0; bus.in_use_imm = 1'b0; bus.in_sext = 1'b0; bus.in_cc = '0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_signed_imm();
        test_stream_stall();
        test_cmp();
        test_imm_error();
        test_addr_overflow();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
